fpu_div_seq: RTL and testbench
==============================

Name: fpu_div_seq

Overview:
- Sequential IEEE-754 single-precision divider that answers FPU requests over a valid/ready handshake.
- The existing FPU path is combinational; this block computes the quotient one bit per clock (restoring division) and returns the result with the FPU status flags.
- It sits behind the FPU op-decode as the responder for op=2'b11 requests.
- It is the multi-cycle counterpart the random tester drives and checks.

Parameters:
ROUND_EN, 1, 1 = round-to-nearest-even on the quotient; 0 = truncate (guard/round/sticky ignored)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
a  input  32  dividend, FP32
b  input  32  divisor, FP32
out_valid  output  1  result valid; held until accepted
out_ready  input  1  consumer accepts the result
result  output  32  quotient, FP32
error  output  1  invalid operation or divide-by-zero
underflow  output  1  result flushed to zero
overflow  output  1  result saturated to infinity

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=32'h0, error/underflow/overflow=0.
- Reset asserted at any point aborts the operation with no output.
- States: IDLE -> UNPACK -> DIVIDE -> ROUND -> DONE -> IDLE. The special-case path is UNPACK -> DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T, latch a and b, go to UNPACK.
  - in_valid outside IDLE is ignored; operands are not re-sampled.
- UNPACK (1 cycle):
  - Split sign/exp/mantissa. Sign = a[31]^b[31].
  - Denormal inputs (exp=0) are treated as zero.
  - Special cases go to DONE with these results:
    - Either input NaN, 0/0, or Inf/Inf -> result 32'h7FC00000, error=1.
    - Finite nonzero / 0 -> signed Inf, error=1.
    - Inf / finite -> signed Inf, no flags.
    - Finite / Inf or 0 / nonzero -> signed zero, no flags.
  - Normal operands:
    - ma={1,a[22:0]}, mb={1,b[22:0]}.
    - If ma<mb, pre-shift ma left 1 and decrement the exponent.
    - Exponent: e = ea - eb + 127 - adj, held in a 10-bit signed register.
- DIVIDE (exactly 26 cycles):
  - Restoring division produces one quotient bit per cycle: 24 mantissa + guard + round.
  - A 5-bit iteration counter counts 25 down to 0.
  - After the last step, sticky = (remainder != 0).
- ROUND (1 cycle):
  - RNE when ROUND_EN=1: increment if G & (R|S|LSB).
  - Mantissa carry-out renormalises and increments e.
  - e >= 255 -> signed Inf, overflow=1.
  - e <= 0 -> signed zero, underflow=1. Denormal results are flushed.
  - Otherwise pack {sign, e[7:0], mant[22:0]}.
- DONE:
  - out_valid=1. result and flags are stable until out_valid&out_ready.
  - On that handshake, out_valid drops and the block returns to IDLE. in_ready=1 on the following cycle; there is no same-cycle turnaround.
- Latency from accept edge T:
  - Normal path: out_valid rises after edge T+28.
  - Special path: out_valid rises after edge T+2.
- Flags are mutually exclusive per result and are cleared when the next request is accepted.
- One operation is in flight at a time; there is no buffering.

Test Plan:
- 6.0/2.0: a=32'h40C00000, b=32'h40000000 -> result 32'h40400000, flags 0, out_valid exactly 28 cycles after accept.
- 1.0/3.0: a=32'h3F800000, b=32'h40400000 -> 32'h3EAAAAAB with ROUND_EN=1; 32'h3EAAAAAA with ROUND_EN=0.
- Specials:
  - 1.0/0.0 -> 32'h7F800000, error=1, latency 2.
  - 0/0 -> 32'h7FC00000, error=1.
  - -2.0/+Inf -> 32'h80000000, no flags.
- Range:
  - 32'h7F7FFFFF/32'h3F000000 -> 32'h7F800000, overflow=1.
  - 32'h00800000/32'h40000000 -> 32'h00000000, underflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags unchanged, in_ready=0. A second in_valid during that time is ignored. Raise out_ready -> out_valid drops next edge and in_ready=1.
- Reset mid-DIVIDE: assert rst_n=0 at cycle 10 of division -> outputs immediately return to reset values. After release, a new 6.0/2.0 request completes correctly.

Source files
------------

// File: rtl/fpu_div_seq.sv
`default_nettype none
// ============================================================================
// fpu_div_seq : sequential FP32 divider, one restoring quotient bit per clock,
//               valid/ready request and result handshakes with status flags.
// Revision    : 1.0
// ============================================================================
module fpu_div_seq #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        error,
    output logic        underflow,
    output logic        overflow
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_ROUND  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_sign;
    logic signed [9:0]  r_exp;
    logic [25:0]        r_rem;
    logic [23:0]        r_div;
    logic [25:0]        r_quo;
    logic [4:0]         r_cnt;
    logic [31:0]        r_result;
    logic               r_error;
    logic               r_underflow;
    logic               r_overflow;
    logic               r_out_valid;

    // ---------------- unpack / special-case classification ----------------
    logic [7:0]         w_ea;
    logic [7:0]         w_eb;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic               w_sign;
    logic               w_special;
    logic [31:0]        w_sp_result;
    logic               w_sp_error;
    logic [23:0]        w_ma;
    logic [23:0]        w_mb;
    logic               w_pre;
    logic signed [9:0]  w_exp_unp;

    assign w_ea     = r_a[30:23];
    assign w_eb     = r_b[30:23];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_a_nan  = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_sign   = r_a[31] ^ r_b[31];

    always_comb begin
        w_special   = 1'b1;
        w_sp_result = 32'h0000_0000;
        w_sp_error  = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_sp_result = 32'h7FC0_0000;
            w_sp_error  = 1'b1;
        end else if (w_a_inf) begin
            w_sp_result = {w_sign, 8'hFF, 23'd0};
        end else if (w_b_zero) begin
            w_sp_result = {w_sign, 8'hFF, 23'd0};
            w_sp_error  = 1'b1;
        end else if (w_b_inf || w_a_zero) begin
            w_sp_result = {w_sign, 31'd0};
        end else begin
            w_special   = 1'b0;
        end
    end

    // Pre-shifting a smaller dividend keeps the first quotient bit at 1.
    assign w_ma      = {1'b1, r_a[22:0]};
    assign w_mb      = {1'b1, r_b[22:0]};
    assign w_pre     = (w_ma < w_mb);
    assign w_exp_unp = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127 - {9'd0, w_pre};

    // ---------------- restoring divide step ----------------
    logic               w_ge;
    logic [25:0]        w_trial;

    assign w_ge    = (r_rem >= {2'b00, r_div});
    assign w_trial = r_rem - {2'b00, r_div};

    // ---------------- round / pack ----------------
    logic [23:0]        w_mant;
    logic               w_guard, w_round, w_sticky, w_inc;
    logic [24:0]        w_sum;
    logic               w_carry;
    logic [22:0]        w_frac;
    logic signed [9:0]  w_exp_rnd;
    logic               w_ovf, w_unf;

    assign w_mant    = r_quo[25:2];
    assign w_guard   = r_quo[1];
    assign w_round   = r_quo[0];
    assign w_sticky  = (r_rem != 26'd0);
    assign w_inc     = ROUND_EN & w_guard & (w_round | w_sticky | w_mant[0]);
    assign w_sum     = {1'b0, w_mant} + {24'd0, w_inc};
    assign w_carry   = w_sum[24];
    assign w_frac    = w_carry ? w_sum[23:1] : w_sum[22:0];
    assign w_exp_rnd = r_exp + {9'd0, w_carry};
    assign w_ovf     = (w_exp_rnd >= 10'sd255);
    assign w_unf     = (w_exp_rnd <= 10'sd0);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (in_valid)                  w_state_nxt = S_UNPACK;
            S_UNPACK: w_state_nxt = w_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (r_cnt == 5'd0)             w_state_nxt = S_ROUND;
            S_ROUND:  w_state_nxt = S_DONE;
            S_DONE:   if (r_out_valid && out_ready)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_rem       <= 26'd0;
            r_div       <= 24'd0;
            r_quo       <= 26'd0;
            r_cnt       <= 5'd0;
            r_result    <= 32'd0;
            r_error     <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a         <= a;
                        r_b         <= b;
                        r_result    <= 32'd0;
                        r_error     <= 1'b0;
                        r_underflow <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                S_UNPACK: begin
                    r_sign <= w_sign;
                    if (w_special) begin
                        r_result <= w_sp_result;
                        r_error  <= w_sp_error;
                    end else begin
                        r_rem <= w_pre ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
                        r_div <= w_mb;
                        r_exp <= w_exp_unp;
                        r_quo <= 26'd0;
                        r_cnt <= 5'd25;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= {(w_ge ? w_trial[24:0] : r_rem[24:0]), 1'b0};
                    r_quo <= {r_quo[24:0], w_ge};
                    r_cnt <= r_cnt - 5'd1;
                end
                S_ROUND: begin
                    r_out_valid <= 1'b1;
                    if (w_ovf) begin
                        r_result   <= {r_sign, 8'hFF, 23'd0};
                        r_overflow <= 1'b1;
                    end else if (w_unf) begin
                        r_result    <= {r_sign, 31'd0};
                        r_underflow <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_rnd[7:0], w_frac};
                    end
                end
                S_DONE: begin
                    // Special results settle one cycle in DONE before being presented.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign error     = r_error;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fpu_div_seq.sv
`default_nettype none
// ============================================================================
// tb_fpu_div_seq : directed and random checks of fpu_div_seq (RNE and truncate
//                  instances) against an integer-arithmetic quotient model.
// Revision       : 1.0
// ============================================================================
module tb_fpu_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;

    logic        in_ready0, out_valid0, err0, unf0, ovf0;
    logic [31:0] res0;
    logic        in_ready1, out_valid1, err1, unf1, ovf1;
    logic [31:0] res1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_div_seq #(.ROUND_EN(1'b1)) u_dut_rne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .result(res0), .error(err0), .underflow(unf0), .overflow(ovf0)
    );

    fpu_div_seq #(.ROUND_EN(1'b0)) u_dut_trn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(res1), .error(err1), .underflow(unf1), .overflow(ovf1)
    );

    // Returns {error, underflow, overflow, result} for x / y.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input bit rnd);
        logic        s;
        int          ex, ey, e;
        logic [63:0] num, den, quot, rem;
        logic [24:0] m;
        logic        g, r, st;
        logic        nx, ny, ix, iy, zx, zy;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (zx && zy) || (ix && iy)) return {3'b100, 32'h7FC00000};
        if (ix) return {3'b000, s, 8'hFF, 23'd0};
        if (zy) return {3'b100, s, 8'hFF, 23'd0};
        if (iy || zx) return {3'b000, s, 31'd0};
        num  = {40'd0, 1'b1, x[22:0]} << 26;
        den  = {40'd0, 1'b1, y[22:0]};
        quot = num / den;
        rem  = num % den;
        e    = ex - ey + 127;
        if (quot >= (64'd1 << 26)) begin
            st   = quot[0] | (rem != 0);
            quot = quot >> 1;
        end else begin
            e  = e - 1;
            st = (rem != 0);
        end
        m = {1'b0, quot[25:2]};
        g = quot[1];
        r = quot[0];
        if (rnd && g && (r || st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {3'b001, s, 8'hFF, 23'd0};
        if (e <= 0)   return {3'b010, s, 31'd0};
        return {3'b000, s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s;
        logic [22:0] f;
        int          k;
        s = 1'($urandom);
        f = 23'($urandom);
        k = int'($urandom_range(0, 9));
        case (k)
            0:       return {s, 31'd0};
            1:       return {s, 8'hFF, 23'd0};
            2:       return {s, 8'hFF, f | 23'd1};
            3:       return {s, 8'($urandom_range(1, 20)), f};
            4:       return {s, 8'($urandom_range(235, 254)), f};
            5:       return {s, 8'd0, f};
            default: return {s, 8'($urandom_range(100, 154)), f};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clk);
        chk("in_ready_idle", {34'd0, in_ready0}, 35'd1);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid0 !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 60) chk("out_valid_timeout", {34'd0, out_valid0}, 35'd1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("out_valid_drop", {34'd0, out_valid0}, 35'd0);
        chk("in_ready_return", {34'd0, in_ready0}, 35'd1);
    endtask

    task automatic check_both(input string tag, input logic [31:0] ta, input logic [31:0] tb);
        chk({tag, "_rne"}, {err0, unf0, ovf0, res0}, model(ta, tb, 1'b1));
        chk({tag, "_trn"}, {err1, unf1, ovf1, res1}, model(ta, tb, 1'b0));
        chk({tag, "_trn_valid"}, {34'd0, out_valid1}, 35'd1);
    endtask

    initial begin
        int          lat;
        logic [31:0] ra, rb;
        logic [34:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready",  {34'd0, in_ready0}, 35'd1);
        chk("reset_out_valid", {34'd0, out_valid0}, 35'd0);
        chk("reset_status",    {err0, unf0, ovf0, res0}, 35'd0);
        rst_n = 1'b1;

        // 6.0 / 2.0, normal-path latency
        issue(32'h40C00000, 32'h40000000);
        wait_valid(lat);
        chk("lat_6div2", 35'(lat), 35'd28);
        chk("res_6div2", {err0, unf0, ovf0, res0}, {3'b000, 32'h40400000});
        check_both("m_6div2", 32'h40C00000, 32'h40000000);
        release_out();

        // 1.0 / 3.0, rounding vs truncation
        issue(32'h3F800000, 32'h40400000);
        wait_valid(lat);
        chk("res_1div3_rne", {err0, unf0, ovf0, res0}, {3'b000, 32'h3EAAAAAB});
        chk("res_1div3_trn", {err1, unf1, ovf1, res1}, {3'b000, 32'h3EAAAAAA});
        release_out();

        // Specials
        issue(32'h3F800000, 32'h00000000);
        wait_valid(lat);
        chk("lat_1div0", 35'(lat), 35'd2);
        chk("res_1div0", {err0, unf0, ovf0, res0}, {3'b100, 32'h7F800000});
        release_out();

        issue(32'h00000000, 32'h00000000);
        wait_valid(lat);
        chk("res_0div0", {err0, unf0, ovf0, res0}, {3'b100, 32'h7FC00000});
        release_out();

        issue(32'hC0000000, 32'h7F800000);
        wait_valid(lat);
        chk("res_m2divinf", {err0, unf0, ovf0, res0}, {3'b000, 32'h80000000});
        release_out();

        // Range limits
        issue(32'h7F7FFFFF, 32'h3F000000);
        wait_valid(lat);
        chk("res_overflow", {err0, unf0, ovf0, res0}, {3'b001, 32'h7F800000});
        release_out();

        issue(32'h00800000, 32'h40000000);
        wait_valid(lat);
        chk("res_underflow", {err0, unf0, ovf0, res0}, {3'b010, 32'h00000000});
        release_out();

        // Backpressure with an ignored second request
        issue(32'h40C00000, 32'h40000000);
        wait_valid(lat);
        held = {err0, unf0, ovf0, res0};
        chk("bp_first", held, {3'b000, 32'h40400000});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
            chk("bp_hold_status", {err0, unf0, ovf0, res0}, {3'b000, 32'h40400000});
            chk("bp_hold_valid",  {34'd0, out_valid0}, 35'd1);
            chk("bp_in_ready",    {34'd0, in_ready0}, 35'd0);
        end
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        chk("bp_no_second_op", {34'd0, out_valid0}, 35'd0);

        // Reset in the middle of DIVIDE
        issue(32'h40C00000, 32'h40000000);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {34'd0, out_valid0}, 35'd0);
        chk("mid_rst_in_ready",  {34'd0, in_ready0}, 35'd1);
        chk("mid_rst_status",    {err0, unf0, ovf0, res0}, 35'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("post_rst_no_output", {34'd0, out_valid0}, 35'd0);
        issue(32'h40C00000, 32'h40000000);
        wait_valid(lat);
        chk("post_rst_lat", 35'(lat), 35'd28);
        chk("post_rst_res", {err0, unf0, ovf0, res0}, {3'b000, 32'h40400000});
        release_out();

        // Random operands against the model
        for (int i = 0; i < 40; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            issue(ra, rb);
            wait_valid(lat);
            check_both($sformatf("rand%0d_%h_%h", i, ra, rb), ra, rb);
            release_out();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
